// File: rtl/fp_result_uart_tx_if.sv
// Result handshake between fp_adder (master) and the UART result sender (slave).
//   result    : 32-bit result word from the adder
//   flags     : 5-bit exception flags accompanying the result
//   valid_in  : adder's valid_out; result/flags are valid this cycle
//   ready_out : sender can accept a result (feeds the adder's ready_in)
interface fp_result_uart_tx_if;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        valid_in;
    logic        ready_out;

    modport master (
        output result,
        output flags,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  result,
        input  flags,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/fp_result_uart_tx.sv
// Accepts one fp_adder result (plus flags) per handshake and sends it as
// UART 8N1: result bytes LSB-first, then an optional {3'b000, flags} byte.
// Backpressures the adder through ready_out while a frame is in flight.
//   clk         : system clock, all state on posedge
//   rst_n       : synchronous active-low reset
//   res_if      : result handshake (slave side)
//   tx          : UART serial line, idle high
//   busy        : high while a frame is being shifted
//   frame_done  : one-cycle pulse at the end of the last stop bit
//   frame_count : completed frames since reset, wraps
module fp_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          SEND_FLAGS   = 1'b1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_result_uart_tx_if.slave   res_if,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic [COUNT_W-1:0]   frame_count
);

    localparam int unsigned NBYTES = SEND_FLAGS ? 5 : 4;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BUF_W  = 40;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BYTE_LAST = 3'(NBYTES - 1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    // Whole frame, shifted right one bit per data bit so the current
    // bit is always frame_buf[0] and the next byte lands in [7:0].
    logic [BUF_W-1:0]  frame_buf;

    logic baud_last_c;
    assign baud_last_c = (baud_cnt == BAUD_LAST);

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (!rst_n) begin
            state            <= IDLE;
            tx               <= 1'b1;
            res_if.ready_out <= 1'b0;
            busy             <= 1'b0;
            frame_count      <= '0;
            baud_cnt         <= '0;
            bit_idx          <= '0;
            byte_idx         <= '0;
            frame_buf        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    // ready_out is the registered acceptance flag, so the
                    // handshake looks at its current value.
                    if (res_if.valid_in && res_if.ready_out) begin
                        frame_buf        <= {3'b000, res_if.flags, res_if.result};
                        res_if.ready_out <= 1'b0;
                        busy             <= 1'b1;
                        tx               <= 1'b0;
                        state            <= START;
                    end else begin
                        res_if.ready_out <= 1'b1;
                    end
                end

                START: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= frame_buf[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_last_c) begin
                        baud_cnt  <= '0;
                        frame_buf <= frame_buf >> 1;
                        if (bit_idx == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= frame_buf[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            // End of the last stop bit: frame complete.
                            byte_idx         <= '0;
                            res_if.ready_out <= 1'b1;
                            busy             <= 1'b0;
                            frame_done       <= 1'b1;
                            frame_count      <= frame_count + COUNT_W'(1);
                            state            <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_result_uart_tx.sv
// Scoreboard bench for fp_result_uart_tx. Two instances: A sends flags with
// a 2-bit frame counter, B sends result bytes only. A UART decoder checks
// every byte against the expected-byte queue; a frame monitor checks each
// frame_done against the expected completion cycle and counter value.
module tb_fp_result_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int unsigned done_cyc;
        logic [15:0] cnt;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result_d;
    logic [4:0]  flags_d;
    logic        valid_d;
    logic        sel;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_result_uart_tx_if if_a ();
    fp_result_uart_tx_if if_b ();

    assign if_a.result   = result_d;
    assign if_a.flags    = flags_d;
    assign if_a.valid_in = valid_d & ~sel;
    assign if_b.result   = result_d;
    assign if_b.flags    = flags_d;
    assign if_b.valid_in = valid_d & sel;

    logic        tx_a, busy_a, done_a;
    logic [1:0]  cnt_a;
    logic        tx_b, busy_b, done_b;
    logic [15:0] cnt_b;

    fp_result_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_FLAGS(1'b1), .COUNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .res_if(if_a),
        .tx(tx_a), .busy(busy_a), .frame_done(done_a), .frame_count(cnt_a)
    );

    fp_result_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_FLAGS(1'b0), .COUNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .res_if(if_b),
        .tx(tx_b), .busy(busy_b), .frame_done(done_b), .frame_count(cnt_b)
    );

    wire        m_tx   = sel ? tx_b : tx_a;
    wire        m_busy = sel ? busy_b : busy_a;
    wire        m_done = sel ? done_b : done_a;
    wire        m_rdy  = sel ? if_b.ready_out : if_a.ready_out;
    wire [15:0] m_cnt  = sel ? cnt_b : {14'b0, cnt_a};

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_bytes[$];
    frame_t      exp_frames[$];
    logic [15:0] model_cnt_a = 16'd0;
    logic [15:0] model_cnt_b = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bytes(input logic [31:0] r, input logic [4:0] f, input int n);
        logic [39:0] w;
        w = {3'b000, f, r};
        for (int i = 0; i < n; i++) exp_bytes.push_back(w[i*8 +: 8]);
    endtask

    task automatic push_frame(input int unsigned hs, input int nb);
        frame_t fr;
        if (sel) begin
            model_cnt_b = model_cnt_b + 16'd1;
            fr.cnt = model_cnt_b;
        end else begin
            model_cnt_a = (model_cnt_a + 16'd1) & 16'h0003;
            fr.cnt = model_cnt_a;
        end
        fr.done_cyc = hs + 32'(nb * 10 * CPB);
        exp_frames.push_back(fr);
    endtask

    // One handshake; optionally abandon the frame with a reset mid byte 2.
    task automatic send(input logic [31:0] r, input logic [4:0] f, input bit abandon);
        int          nb;
        int          guard;
        int unsigned hs;
        nb    = sel ? 4 : 5;
        guard = 0;
        @(posedge clk); #1;
        result_d = r;
        flags_d  = f;
        valid_d  = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!m_rdy && guard < 2000);
        if (!m_rdy) begin
            chk("ready_timeout", 64'(m_rdy), 64'(1));
            valid_d = 1'b0;
            return;
        end
        push_bytes(r, f, abandon ? 2 : nb);
        @(posedge clk); #1;
        hs       = cyc;
        valid_d  = 1'b0;
        result_d = ~r;
        flags_d  = ~f;
        if (!abandon) begin
            push_frame(hs, nb);
        end else begin
            while (cyc < hs + 32'(10 * CPB * 2 + 5 * CPB)) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_tx_high", 64'(m_tx), 64'(1));
            chk("abort_busy", 64'(m_busy), 64'(0));
            chk("abort_ready_low", 64'(m_rdy), 64'(0));
            chk("abort_count", 64'(m_cnt), 64'(model_cnt_a));
            @(negedge clk);
            chk("abort_ready_back", 64'(m_rdy), 64'(1));
        end
    endtask

    // valid_in held high while result changes every cycle.
    task automatic stream(input int nframes);
        int          got;
        int          guard;
        int unsigned hs;
        int unsigned done_prev;
        got       = 0;
        guard     = 0;
        done_prev = 0;
        @(posedge clk); #1;
        valid_d  = 1'b1;
        result_d = 32'h5000_0000 ^ (cyc * 32'h0101_0013);
        flags_d  = 5'(cyc);
        while (got < nframes && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (m_rdy) begin
                push_bytes(result_d, flags_d, 5);
                @(posedge clk); #1;
                hs = cyc;
                if (got > 0) chk("b2b_handshake_cycle", 64'(hs), 64'(done_prev + 1));
                push_frame(hs, 5);
                done_prev = hs + 32'(5 * 10 * CPB);
                got++;
            end else begin
                @(posedge clk); #1;
            end
            result_d = 32'h5000_0000 ^ (cyc * 32'h0101_0013);
            flags_d  = 5'(cyc);
        end
        valid_d = 1'b0;
        if (got < nframes) chk("stream_timeout", 64'(got), 64'(nframes));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_bytes.size() == 0 && exp_frames.size() == 0 && m_rdy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk("idle_timeout", 64'(exp_frames.size()), 64'(0));
    endtask

    // UART decoder: samples each bit in its middle, aborts on reset.
    initial begin : byte_mon
        logic [7:0] b;
        logic       start_bit;
        logic       stop_bit;
        bit         abort;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_tx === 1'b0) begin
                abort     = 1'b0;
                b         = '0;
                start_bit = 1'b1;
                stop_bit  = 1'b0;
                for (int off = 1; off <= CPB * 9 + CPB / 2; off++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (off == CPB / 2) start_bit = m_tx;
                    for (int i = 0; i < 8; i++)
                        if (off == CPB * (1 + i) + CPB / 2) b[i] = m_tx;
                    if (off == CPB * 9 + CPB / 2) stop_bit = m_tx;
                end
                if (!abort) begin
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte (cycle %0d)", b, cyc);
                    end else begin
                        e = exp_bytes.pop_front();
                        chk("start_bit", 64'(start_bit), 64'(0));
                        chk("tx_byte", 64'(b), 64'(e));
                        chk("stop_bit", 64'(stop_bit), 64'(1));
                    end
                end
            end
        end
    end

    // Frame completion monitor.
    initial begin : frame_mon
        logic   prev_rdy;
        bit     chk_low;
        frame_t fr;
        prev_rdy = 1'b0;
        chk_low  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_low) begin
                chk("done_one_cycle", 64'(m_done), 64'(0));
                chk_low = 1'b0;
            end else if (m_done === 1'b1) begin
                if (exp_frames.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got pulse, expected none (cycle %0d)", cyc);
                end else begin
                    fr = exp_frames.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(fr.done_cyc));
                    chk("frame_count", 64'(m_cnt), 64'(fr.cnt));
                    chk("ready_at_done", 64'(m_rdy), 64'(1));
                    chk("ready_before_done", 64'(prev_rdy), 64'(0));
                    chk("busy_at_done", 64'(m_busy), 64'(0));
                    chk("tx_idle_at_done", 64'(m_tx), 64'(1));
                end
                chk_low = 1'b1;
            end
            prev_rdy = m_rdy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n    = 1'b0;
        valid_d  = 1'b0;
        sel      = 1'b0;
        result_d = '0;
        flags_d  = '0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_tx", 64'(m_tx), 64'(1));
            chk("reset_ready", 64'(m_rdy), 64'(0));
            chk("reset_busy", 64'(m_busy), 64'(0));
            chk("reset_count", 64'(m_cnt), 64'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_release_edge", 64'(m_rdy), 64'(0));
        @(negedge clk);
        chk("ready_after_release", 64'(m_rdy), 64'(1));
        chk("ready_b_after_release", 64'(if_b.ready_out), 64'(1));

        // Abandoned frame, then a clean one.
        send(32'h1234_5678, 5'h1F, 1'b1);
        send(32'h3F80_0000, 5'b00001, 1'b0);
        wait_idle();

        // Back-to-back frames with continuously valid, changing input.
        stream(3);
        wait_idle();

        // Counter wraps 3 -> 0 -> 1 on the 2-bit instance.
        send(32'hC0A8_0101, 5'h0A, 1'b0);
        wait_idle();

        // Result-only instance.
        sel = 1'b1;
        send(32'hDEAD_BEEF, 5'h15, 1'b0);
        wait_idle();
        send(32'h0000_00FF, 5'h00, 1'b0);
        wait_idle();

        chk("leftover_bytes", 64'(exp_bytes.size()), 64'(0));
        chk("leftover_frames", 64'(exp_frames.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
